fir_mac_sequencer: RTL

//  Sequences one 40-tap FIR evaluation per input sample over the registered coefficient ROM (coef).

---
 rtl/fir_mac_sequencer.sv | 111 +++++++++++
 1 files changed

// File: rtl/fir_mac_sequencer.sv
// Sequential 40-tap FIR: one MAC per cycle over a circular sample history,
// driving a coefficient ROM address and emitting one saturated output per input sample.
module fir_mac_sequencer #(
    parameter int ORDER     = 39,
    parameter int ORDER_MSB = 5,
    parameter int DATA_MSB  = 15,
    parameter int ACC_W     = 38,
    parameter int SHIFT     = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_MSB:0]    sample_in,
    input  logic                 sample_valid,
    output logic [ORDER_MSB:0]   coef_addr,
    input  logic [DATA_MSB:0]    coef_bits,
    output logic [DATA_MSB:0]    y_out,
    output logic                 y_valid,
    output logic                 busy,
    output logic                 overrun
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

    localparam int unsigned AW   = ORDER_MSB + 1;
    localparam int unsigned PW   = 2 * (DATA_MSB + 1);
    localparam int unsigned TAPS = ORDER + 1;
    localparam logic [ORDER_MSB:0] TAP_LAST = AW'(ORDER);
    localparam logic [ORDER_MSB:0] ONE      = AW'(1);

    state_t state, state_nx;

    logic [DATA_MSB:0]        hist [0:ORDER];
    logic [ORDER_MSB:0]       wr_ptr, tap, rd_idx;
    logic signed [DATA_MSB:0] s_d;
    logic signed [PW-1:0]     prod;
    logic signed [ACC_W-1:0]  acc, acc_sum, acc_sh;
    logic                     pos_ovf, neg_ovf;
    logic [DATA_MSB:0]        y_sat;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (sample_valid) state_nx = RUN;
            RUN:     if (tap == TAP_LAST) state_nx = DRAIN;
            DRAIN:   state_nx = OUT;
            OUT:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Walk backwards from the newest entry, wrapping modulo ORDER+1
    assign rd_idx = (wr_ptr >= tap) ? (wr_ptr - tap) : (wr_ptr + TAP_LAST + ONE - tap);

    // coef_bits belongs to the address registered one cycle earlier, as does s_d
    assign prod    = PW'($signed(coef_bits)) * PW'(s_d);
    assign acc_sum = acc + $signed({{(ACC_W - PW){prod[PW-1]}}, prod});
    assign acc_sh  = acc >>> SHIFT;

    assign pos_ovf = !acc_sh[ACC_W-1] && (|acc_sh[ACC_W-2:DATA_MSB]);
    assign neg_ovf =  acc_sh[ACC_W-1] && !(&acc_sh[ACC_W-2:DATA_MSB]);
    assign y_sat   = pos_ovf ? {1'b0, {DATA_MSB{1'b1}}} :
                     neg_ovf ? {1'b1, {DATA_MSB{1'b0}}} :
                               acc_sh[DATA_MSB:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < TAPS; i++) hist[i] <= '0;
            wr_ptr    <= '0;
            tap       <= '0;
            acc       <= '0;
            s_d       <= '0;
            coef_addr <= '0;
            y_out     <= '0;
            y_valid   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            y_valid <= 1'b0;
            if (sample_valid && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (sample_valid) begin
                        hist[wr_ptr] <= sample_in;
                        tap          <= '0;
                        acc          <= '0;
                    end
                end
                RUN: begin
                    coef_addr <= tap;
                    s_d       <= $signed(hist[rd_idx]);
                    if (tap != '0) acc <= acc_sum;
                    tap <= tap + ONE;
                end
                DRAIN: acc <= acc_sum;
                OUT: begin
                    y_out   <= y_sat;
                    y_valid <= 1'b1;
                    wr_ptr  <= (wr_ptr == TAP_LAST) ? '0 : wr_ptr + ONE;
                end
                default: ;
            endcase
        end
    end

endmodule
